// File: rtl/ahb_lite_slave_mux_tmo.sv
// AHB-Lite slave-side response multiplexer with integrated default slave
// (two-cycle ERROR on bad decode) and a per-transfer wait-state watchdog.
module ahb_lite_slave_mux_tmo #(
  parameter int unsigned NUM_SLAVES     = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic                             HREADY,
  input  logic [1:0]                       HTRANS,
  input  logic [NUM_SLAVES-1:0]            HSEL_A,
  input  logic [NUM_SLAVES-1:0]            HREADYOUT_A,
  input  logic [NUM_SLAVES-1:0]            HRESP_A,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_A,
  output logic                             HREADYOUT,
  output logic                             HRESP,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  output logic                             DECERR_PULSE,
  output logic                             TIMEOUT_PULSE,
  output logic [15:0]                      ERR_COUNT
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SLAVE, ERR1, ERR2} state_t;

  state_t                  state, state_nxt;
  logic [NUM_SLAVES-1:0]   sel_reg, sel_nxt;
  logic [CW-1:0]           wait_cnt, wait_nxt;
  logic                    tmo_flag, tmo_nxt;
  logic                    err_inc;
  logic                    sample;
  logic                    hsel_onehot;
  logic                    sel_ready, sel_resp;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic [15:0]             err_cnt;
  logic                    unused_htrans0;

  assign unused_htrans0 = HTRANS[0];

  assign hsel_onehot = (HSEL_A != '0) && ((HSEL_A & (HSEL_A - NUM_SLAVES'(1))) == '0);

  // sel_reg is one-hot (or zero), so an AND-OR reduction forms the mux
  always_comb begin
    sel_ready = 1'b0;
    sel_resp  = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel_reg[i]) begin
        sel_ready = sel_ready | HREADYOUT_A[i];
        sel_resp  = sel_resp  | HRESP_A[i];
        sel_rdata = sel_rdata | HRDATA_A[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_reg;
    wait_nxt  = wait_cnt;
    tmo_nxt   = tmo_flag;
    err_inc   = 1'b0;
    sample    = 1'b0;
    case (state)
      IDLE: sample = HREADY;
      SLAVE: begin
        if (sel_ready) begin
          sample = HREADY;
        end else begin
          if (wait_cnt != TMO) wait_nxt = wait_cnt + CW'(1);
          if ((TIMEOUT_CYCLES != 0) && (wait_nxt == TMO)) begin
            state_nxt = ERR1;
            tmo_nxt   = 1'b1;
            err_inc   = 1'b1;
          end
        end
      end
      ERR1:    state_nxt = ERR2;
      ERR2:    sample = HREADY;
      default: state_nxt = IDLE;
    endcase

    if (sample) begin
      if (!HTRANS[1]) begin
        state_nxt = IDLE;
      end else if (hsel_onehot) begin
        state_nxt = SLAVE;
        sel_nxt   = HSEL_A;
        wait_nxt  = '0;
      end else begin
        state_nxt = ERR1;
        tmo_nxt   = 1'b0;
        err_inc   = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= IDLE;
      sel_reg  <= '0;
      wait_cnt <= '0;
      tmo_flag <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      sel_reg  <= sel_nxt;
      wait_cnt <= wait_nxt;
      tmo_flag <= tmo_nxt;
      if (err_inc && (err_cnt != '1)) err_cnt <= err_cnt + 16'd1;
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    case (state)
      SLAVE: begin
        HREADYOUT = sel_ready;
        HRESP     = sel_resp;
        HRDATA    = sel_rdata;
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b1;
      end
      default: ;
    endcase
  end

  // tmo_flag records why ERR1 was entered, selecting which pulse fires
  assign DECERR_PULSE  = (state == ERR1) && !tmo_flag;
  assign TIMEOUT_PULSE = (state == ERR1) &&  tmo_flag;
  assign ERR_COUNT     = err_cnt;

endmodule

// File: tb/tb_ahb_lite_slave_mux_tmo.sv
// Table-driven scoreboard bench: one DUT with TIMEOUT_CYCLES=4 and one with
// the watchdog disabled share the stimulus.
module tb_ahb_lite_slave_mux_tmo;

  localparam int NS = 16;
  localparam int DW = 32;

  typedef struct {
    string       name;
    bit          rst;
    bit          hr;
    logic [1:0]  tr;
    logic [15:0] sel;
    logic [15:0] rdy;
    logic [15:0] rsp;
    bit          chk;
    bit          use0;
    logic [51:0] exp;
  } vec_t;

  logic              clk = 1'b0;
  logic              hreset = 1'b1;
  logic              hready = 1'b1;
  logic [1:0]        htrans = 2'b00;
  logic [NS-1:0]     hsel = '0;
  logic [NS-1:0]     hreadyout_a = '1;
  logic [NS-1:0]     hresp_a = '0;
  logic [NS*DW-1:0]  hrdata_a;

  logic              r4, p4, de4, t4;
  logic [DW-1:0]     d4;
  logic [15:0]       c4;
  logic              r0, p0, de0, t0;
  logic [DW-1:0]     d0;
  logic [15:0]       c0;

  int checks = 0;
  int passed = 0;
  vec_t sbq[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  ahb_lite_slave_mux_tmo #(.NUM_SLAVES(NS), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)) dut (
    .HCLK(clk), .HRESET(hreset), .HREADY(hready), .HTRANS(htrans), .HSEL_A(hsel),
    .HREADYOUT_A(hreadyout_a), .HRESP_A(hresp_a), .HRDATA_A(hrdata_a),
    .HREADYOUT(r4), .HRESP(p4), .HRDATA(d4),
    .DECERR_PULSE(de4), .TIMEOUT_PULSE(t4), .ERR_COUNT(c4)
  );

  ahb_lite_slave_mux_tmo #(.NUM_SLAVES(NS), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(0)) dut0 (
    .HCLK(clk), .HRESET(hreset), .HREADY(hready), .HTRANS(htrans), .HSEL_A(hsel),
    .HREADYOUT_A(hreadyout_a), .HRESP_A(hresp_a), .HRDATA_A(hrdata_a),
    .HREADYOUT(r0), .HRESP(p0), .HRDATA(d0),
    .DECERR_PULSE(de0), .TIMEOUT_PULSE(t0), .ERR_COUNT(c0)
  );

  function automatic logic [31:0] sl(input int i);
    return (i == 3) ? 32'hDEADBEEF : (32'hA5000000 | 32'(i));
  endfunction

  function automatic logic [15:0] b(input int i);
    logic [15:0] one = 16'd1;
    return one << i;
  endfunction

  function automatic logic [51:0] e(input logic r, input logic p, input logic [31:0] d,
                                    input logic de, input logic t, input logic [15:0] c);
    return {r, p, d, de, t, c};
  endfunction

  function automatic vec_t mk(input string n, input bit rst, input bit hr, input logic [1:0] tr,
                              input logic [15:0] sel, input logic [15:0] rdy,
                              input logic [15:0] rsp, input bit chk, input bit use0,
                              input logic [51:0] ex);
    vec_t v;
    v.name = n; v.rst = rst; v.hr = hr; v.tr = tr; v.sel = sel;
    v.rdy = rdy; v.rsp = rsp; v.chk = chk; v.use0 = use0; v.exp = ex;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    hreset      = v.rst;
    hready      = v.hr;
    htrans      = v.tr;
    hsel        = v.sel;
    hreadyout_a = v.rdy;
    hresp_a     = v.rsp;
    sbq.push_back(v);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      vec_t v;
      logic [51:0] act;
      v = sbq.pop_front();
      if (v.chk) begin
        act = v.use0 ? {r0, p0, d0, de0, t0, c0} : {r4, p4, d4, de4, t4, c4};
        checks++;
        if (act === v.exp) passed++;
        else $display("FAIL %s: actual rdy,resp,data,dec,tmo,cnt=%h required=%h", v.name, act, v.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL time_limit: bench did not complete, actual=running required=done");
    $fatal(1);
  end

  initial begin
    logic [15:0] all, n2, n7;
    for (int i = 0; i < NS; i++) hrdata_a[i*DW +: DW] = sl(i);
    all = 16'hFFFF;
    n2  = ~b(2);
    n7  = ~b(7);

    tbl.push_back(mk("rst",         1, 1, 2'b00, 16'h0, all, 16'h0, 0, 0, e(1,0,0,0,0,0)));
    tbl.push_back(mk("reset_state", 0, 1, 2'b00, 16'h0, all, 16'h0, 1, 0, e(1,0,0,0,0,0)));
    tbl.push_back(mk("s3_addr",     0, 1, 2'b10, b(3),  all, 16'h0, 1, 0, e(1,0,0,0,0,0)));
    tbl.push_back(mk("s3_data",     0, 1, 2'b10, b(5),  all, 16'h0, 1, 0, e(1,0,32'hDEADBEEF,0,0,0)));
    tbl.push_back(mk("s5_b2b_data", 0, 1, 2'b00, 16'h0, all, 16'h0, 1, 0, e(1,0,sl(5),0,0,0)));
    tbl.push_back(mk("s5_idle",     0, 1, 2'b00, 16'h0, all, 16'h0, 1, 0, e(1,0,0,0,0,0)));
    tbl.push_back(mk("de0_addr",    0, 1, 2'b10, 16'h0, all, 16'h0, 1, 0, e(1,0,0,0,0,0)));
    tbl.push_back(mk("de0_err1",    0, 1, 2'b00, 16'h0, all, 16'h0, 1, 0, e(0,1,0,1,0,1)));
    tbl.push_back(mk("de0_err2",    0, 1, 2'b10, 16'h5, all, 16'h0, 1, 0, e(1,1,0,0,0,1)));
    tbl.push_back(mk("de5_err1",    0, 1, 2'b00, 16'h0, all, 16'h0, 1, 0, e(0,1,0,1,0,2)));
    tbl.push_back(mk("de5_err2",    0, 1, 2'b00, 16'h0, all, 16'h0, 1, 0, e(1,1,0,0,0,2)));
    tbl.push_back(mk("de_idle",     0, 1, 2'b00, 16'h0, all, 16'h0, 1, 0, e(1,0,0,0,0,2)));
    tbl.push_back(mk("s2_addr",     0, 1, 2'b10, b(2),  n2,  16'h0, 1, 0, e(1,0,0,0,0,2)));
    tbl.push_back(mk("s2_wait1",    0, 1, 2'b00, 16'h0, n2,  16'h0, 1, 0, e(0,0,sl(2),0,0,2)));
    tbl.push_back(mk("s2_wait2",    0, 1, 2'b00, 16'h0, n2,  16'h0, 1, 0, e(0,0,sl(2),0,0,2)));
    tbl.push_back(mk("s2_err_a",    0, 1, 2'b00, 16'h0, n2,  b(2),  1, 0, e(0,1,sl(2),0,0,2)));
    tbl.push_back(mk("s2_err_b",    0, 1, 2'b00, 16'h0, all, b(2),  1, 0, e(1,1,sl(2),0,0,2)));
    tbl.push_back(mk("s2_idle",     0, 1, 2'b00, 16'h0, all, 16'h0, 1, 0, e(1,0,0,0,0,2)));
    tbl.push_back(mk("t7_addr",     0, 1, 2'b10, b(7),  n7,  16'h0, 1, 0, e(1,0,0,0,0,2)));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk("t7_wait",   0, 1, 2'b00, 16'h0, n7,  16'h0, 1, 0, e(0,0,sl(7),0,0,2)));
    tbl.push_back(mk("t7_err1",     0, 1, 2'b00, 16'h0, n7,  16'h0, 1, 0, e(0,1,0,0,1,3)));
    tbl.push_back(mk("t7_err2",     0, 1, 2'b10, b(1),  n7,  16'h0, 1, 0, e(1,1,0,0,0,3)));
    tbl.push_back(mk("s1_data",     0, 1, 2'b00, 16'h0, n7,  16'h0, 1, 0, e(1,0,sl(1),0,0,3)));
    tbl.push_back(mk("s1_idle",     0, 1, 2'b00, 16'h0, all, 16'h0, 1, 0, e(1,0,0,0,0,3)));
    tbl.push_back(mk("hr0_idle",    0, 0, 2'b10, b(3),  all, 16'h0, 1, 0, e(1,0,0,0,0,3)));
    tbl.push_back(mk("hr0_hold",    0, 1, 2'b00, 16'h0, all, 16'h0, 1, 0, e(1,0,0,0,0,3)));
    tbl.push_back(mk("r_addr",      0, 1, 2'b10, 16'h0, all, 16'h0, 1, 0, e(1,0,0,0,0,3)));
    tbl.push_back(mk("r_err1",      1, 1, 2'b00, 16'h0, all, 16'h0, 1, 0, e(0,1,0,1,0,4)));
    tbl.push_back(mk("r_after",     0, 1, 2'b00, 16'h0, all, 16'h0, 1, 0, e(1,0,0,0,0,0)));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Watchdog disabled: a long stall never aborts, then completes normally.
    apply(mk("z_addr", 0, 1, 2'b10, b(7), n7, 16'h0, 1, 1, e(1,0,0,0,0,0)));
    for (int k = 0; k < 1000; k++)
      apply(mk("z_stall", 0, 1, 2'b00, 16'h0, n7, 16'h0, 1, 1, e(0,0,sl(7),0,0,0)));
    apply(mk("z_done", 0, 1, 2'b00, 16'h0, all, 16'h0, 1, 1, e(1,0,sl(7),0,0,0)));
    apply(mk("z_idle", 0, 1, 2'b00, 16'h0, all, 16'h0, 1, 1, e(1,0,0,0,0,0)));

    repeat (3) @(posedge clk);
    checks++;
    if (sbq.size() == 0) passed++;
    else $display("FAIL sb_drain: actual=%0d pending required=0", sbq.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ahb_lite_slave_mux_tmo.md
# ahb_lite_slave_mux_tmo

Parametrised AHB-Lite slave-side response multiplexer for the system interconnect. It registers the address-phase slave select and routes HREADYOUT/HRESP/HRDATA from the selected slave during the data phase. It adds an integrated default slave that returns a two-cycle ERROR for unmapped or multiply-decoded transfers. It adds a per-transfer wait-state watchdog that aborts a stalled slave with ERROR and reports decode and timeout events.

## Interface
- NUM_SLAVES, 16, number of slave ports (1..32)
- DATA_WIDTH, 32, HRDATA width per slave
- TIMEOUT_CYCLES, 256, consecutive wait states tolerated before abort; 0 disables watchdog
- HCLK  in  1  bus clock; all logic on rising edge
- HRESET  in  1  synchronous, active-high reset
- HREADY  in  1  bus-level ready (fed back from HREADYOUT through interconnect)
- HTRANS  in  2  master transfer type; bit 1 = active transfer (NONSEQ/SEQ)
- HSEL_A  in  NUM_SLAVES  address-phase select from decoder, one bit per slave
- HREADYOUT_A  in  NUM_SLAVES  per-slave ready
- HRESP_A  in  NUM_SLAVES  per-slave response
- HRDATA_A  in  NUM_SLAVES*DATA_WIDTH  packed read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
- HREADYOUT  out  1  muxed ready to master
- HRESP  out  1  muxed response to master
- HRDATA  out  DATA_WIDTH  muxed read data
- DECERR_PULSE  out  1  one-cycle pulse on entry to decode-error response
- TIMEOUT_PULSE  out  1  one-cycle pulse on watchdog abort
- ERR_COUNT  out  16  saturating count of decode errors + timeouts

## Operation
- States: IDLE, SLAVE, ERR1, ERR2.
- Address phase sampled only when HREADY=1 (in IDLE, in SLAVE on the completing cycle, in ERR2):
  - HTRANS[1]=0 -> IDLE.
  - HTRANS[1]=1, HSEL_A exactly one-hot -> SLAVE; selReg <= HSEL_A; wait counter cleared.
  - HTRANS[1]=1, HSEL_A zero or multi-hot -> ERR1; DECERR_PULSE next cycle.
- IDLE: HREADYOUT=1, HRESP=0, HRDATA=0.
- SLAVE: outputs = HREADYOUT_A/HRESP_A/HRDATA_A of the slave indexed by selReg, combinationally.
  - Each cycle with selected HREADYOUT_A=0, the wait counter increments, saturating at TIMEOUT_CYCLES.
  - TIMEOUT_CYCLES>0 and counter reaches TIMEOUT_CYCLES with selected ready still 0 -> ERR1; TIMEOUT_PULSE asserted in the ERR1 cycle.
- ERR1: HREADYOUT=0, HRESP=1, HRDATA=0; always -> ERR2.
- ERR2: HREADYOUT=1, HRESP=1, HRDATA=0; samples next address phase as above.
- After a timeout abort, late responses from the aborted slave are ignored; selReg is overwritten by the next sample.
- ERR_COUNT increments by 1 on each ERR1 entry and holds at 16'hFFFF.
- Slave ERROR responses (HRESP_A=1) are forwarded unchanged and are not counted.
- The wait counter is $clog2(TIMEOUT_CYCLES+1) bits wide, minimum 1.

## Timing
- Reset (HRESET=1 at a rising edge) has the following result on the next cycle:
  - state=IDLE, selReg=0, counters=0.
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - DECERR_PULSE=0, TIMEOUT_PULSE=0, ERR_COUNT=0.
- Reset mid-transfer or mid-error abandons the response immediately.
- Select latency: HSEL_A sampled at edge N drives mux selection from cycle N+1 (the data phase).
- Zero-wait slave: data and OKAY are visible in the first data-phase cycle.
- Decode error: exactly 2 response cycles (ERR1, ERR2); DECERR_PULSE coincides with ERR1.
- Timeout: the slave is visible for TIMEOUT_CYCLES wait cycles, then ERR1 and ERR2; total data phase is TIMEOUT_CYCLES+2 cycles.
- Back-to-back transfers: sampling in ERR2 or in a completing SLAVE cycle leads to the next state without an idle bubble.
- HREADY=0 while in IDLE (another master stall) holds state; HSEL_A is ignored.
- Simultaneous decode error and ERR_COUNT at 0xFFFF: the response is still generated and the count stays at 0xFFFF.

## Test plan
- Reset, then slave 3 selected with HTRANS=NONSEQ and HREADYOUT_A[3]=1, HRDATA_A slice 3=0xDEADBEEF -> next cycle HRDATA=0xDEADBEEF, HREADYOUT=1, HRESP=0.
- HTRANS=NONSEQ with HSEL_A=0, then HSEL_A=0x0005 -> each gives {HREADYOUT,HRESP}=01 then 11, DECERR_PULSE once per transfer, ERR_COUNT=2.
- TIMEOUT_CYCLES=4, slave 7 holds HREADYOUT_A low forever -> HREADYOUT=0 for 4 cycles with HRESP=0, then 01, 11; TIMEOUT_PULSE one cycle; next transfer to slave 1 completes normally.
- Slave 2 with 2 wait states and then HRESP_A=1 for two cycles (0 then 1 on ready) -> forwarded exactly; ERR_COUNT unchanged.
- HRESET asserted during ERR1 -> next cycle HREADYOUT=1, HRESP=0, ERR_COUNT=0; TIMEOUT_CYCLES=0 with a 1000-cycle stall -> no abort.
